addsub_pipe: RTL

- Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the team's fixed 4-bit ripple add/sub block.
- The operand width is split into STAGES equal chunks. Each chunk is added in its own pipeline stage, and the carry is registered between stages.
- Valid/ready handshakes on input and output. Outputs the result plus carry/borrow, overflow, zero and negative flags.
- Sits between the operand register file and result writeback in the datapath.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/addsub_chunk.sv | 28 ++
 rtl/addsub_fa.sv | 13 +
 rtl/addsub_pipe.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined add/sub datapath.
// Flag bit positions and chunk extraction used by every stage.
package addsub_pkg;

  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;
  localparam int MAX_W     = 64;

  // Returns chunk k (cw bits wide) of vec, right-aligned and zero-extended.
  function automatic logic [MAX_W-1:0] chunk_of(input logic [MAX_W-1:0] vec,
                                                input int k, input int cw);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << cw) - MAX_W'(1);
    return (vec >> (k * cw)) & mask;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit ripple adder made of full adder cells.
module addsub_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  logic [CW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CW; i++) begin : g_bit
    addsub_fa u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CW];

endmodule

// File: rtl/addsub_fa.sv
// One-bit full adder cell, the building block of the chunk ripple adders.
module addsub_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one CW-bit chunk per stage,
// carry registered between stages, valid/ready handshake on both sides.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);

  localparam int CW  = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  logic                 advance;
  logic                 out_vld;
  logic [WIDTH-1:0]     sum_q;
  logic [NUM_FLAGS-1:0] flags_q;

  // Stage inputs: element k feeds stage k. Operands carry the still-unused
  // upper chunks (skew); s_p carries the already-completed lower chunks.
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             cy_p  [STAGES];
  logic             sub_p [STAGES];
  logic             vld_p [STAGES];

  assign advance  = !out_vld | OutReady;
  assign InReady  = advance;

  assign a_p[0]   = A;
  assign b_p[0]   = B ^ {WIDTH{Sub}};
  assign s_p[0]   = '0;
  assign cy_p[0]  = Sub;
  assign sub_p[0] = Sub;
  assign vld_p[0] = InValid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0]    ch_a;
    logic [CW-1:0]    ch_b;
    logic [CW-1:0]    ch_s;
    logic             ch_c;
    logic [WIDTH-1:0] s_new;

    assign ch_a  = CW'(chunk_of(MAX_W'(a_p[k]), k, CW));
    assign ch_b  = CW'(chunk_of(MAX_W'(b_p[k]), k, CW));
    assign s_new = s_p[k] | (WIDTH'(ch_s) << (k * CW));

    addsub_chunk #(.CW(CW)) u_chunk (
      .a   (ch_a),
      .b   (ch_b),
      .cin (cy_p[k]),
      .sum (ch_s),
      .cout(ch_c)
    );

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             cy_q;
      logic             sub_q;
      logic             vld_q;

      // ---- stage k -> stage k+1 boundary ----
      always_ff @(posedge Clk) begin
        if (Reset) begin
          vld_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
          cy_q  <= 1'b0;
          sub_q <= 1'b0;
        end else if (advance) begin
          vld_q <= vld_p[k];
          if (vld_p[k]) begin
            a_q   <= a_p[k];
            b_q   <= b_p[k];
            s_q   <= s_new;
            cy_q  <= ch_c;
            sub_q <= sub_p[k];
          end
        end
      end

      assign a_p[k+1]   = a_q;
      assign b_p[k+1]   = b_q;
      assign s_p[k+1]   = s_q;
      assign cy_p[k+1]  = cy_q;
      assign sub_p[k+1] = sub_q;
      assign vld_p[k+1] = vld_q;
    end else begin : g_last
      logic [NUM_FLAGS-1:0] fl;

      always_comb begin
        fl         = '0;
        fl[FLAG_C] = ch_c ^ sub_p[k];
        fl[FLAG_V] = (a_p[k][MSB] == b_p[k][MSB]) & (s_new[MSB] != a_p[k][MSB]);
        fl[FLAG_Z] = ~|s_new;
        fl[FLAG_N] = s_new[MSB];
      end

      // ---- final stage -> output register boundary ----
      always_ff @(posedge Clk) begin
        if (Reset) begin
          out_vld <= 1'b0;
          sum_q   <= '0;
          flags_q <= '0;
        end else if (advance) begin
          out_vld <= vld_p[k];
          if (vld_p[k]) begin
            sum_q   <= s_new;
            flags_q <= fl;
          end
        end
      end
    end
  end

  assign OutValid = out_vld;
  assign Sum      = sum_q;
  assign Cout     = flags_q[FLAG_C];
  assign Overflow = flags_q[FLAG_V];
  assign Zero     = flags_q[FLAG_Z];
  assign Negative = flags_q[FLAG_N];

endmodule
